shake128_absorb_arbiter: RTL
============================

// Module: shake128_absorb_arbiter
// PURPOSE
//  Shares one shake128_absorb engine (rate 168 B) among NUM_REQ requesters (e.g. ExpandA/ExpandS
//  sampler lanes). Round-robin arbitration; registers the granted requester's state/message into
//  the engine, pulses its start, waits for done, returns the absorbed state and position to the
//  granted requester with a one-cycle ack. No engine instance inside; engine is wired at parent level.
// PARAMETERS
//  NUM_REQ     4      number of requesters, 2..8
//  IN_LEN      32     message bytes per request; must equal engine in_len
//  TIMEOUT     4096   cycles in WAIT before aborting with err pulse; 0 disables watchdog
// PORTS
//  clock          in   1               system clock, rising edge
//  reset          in   1               asynchronous, active-low reset
//  req            in   NUM_REQ         level request per requester, held until its ack
//  req_s_in       in   NUM_REQ*1600    flattened Keccak state per requester (slot k = [k*1600 +: 1600])
//  req_pos_in     in   NUM_REQ*32      flattened absorb position per requester
//  req_in         in   NUM_REQ*IN_LEN*8 flattened message per requester
//  req_inlen      in   NUM_REQ*64      flattened valid byte count per requester
//  ack            out  NUM_REQ         one-hot 1-cycle pulse: result for that requester valid
//  err            out  NUM_REQ         one-hot 1-cycle pulse: watchdog abort for that requester
//  resp_s_out     out  1600            absorbed state, valid while ack bit high
//  resp_pos_out   out  32              new absorb position, valid while ack bit high
//  busy           out  1               high in every state except IDLE
//  grant_idx      out  3               index of current/last granted requester
//  eng_start      out  1               start pulse to engine
//  eng_s_in       out  1600            registered state to engine
//  eng_pos_in     out  32              registered position to engine
//  eng_in         out  IN_LEN*8        registered message to engine
//  eng_inlen      out  64              registered length to engine
//  eng_s_out      in   1600            engine result state
//  eng_pos_out    in   32              engine result position
//  eng_done       in   1               engine completion (level or pulse; first high sample counts)
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, rr_ptr=0, every output register 0 (ack, err, eng_start,
//   busy, grant_idx, resp_*, eng_*). Reset mid-operation abandons the job silently; no ack/err.
//  FSM: IDLE -> LOAD -> START -> WAIT -> RESP -> IDLE; WAIT -> ABORT -> IDLE on timeout.
//  IDLE: if any req bit high, pick first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ;
//   latch grant_idx and that slot's s/pos/in/inlen into eng_* registers at the edge; go LOAD.
//  LOAD: one settle cycle (eng_* stable); go START.
//  START: eng_start=1 for exactly this cycle; watchdog counter cleared; go WAIT.
//  WAIT: eng_start=0; eng_done ignored in START, sampled from first WAIT cycle; on eng_done=1
//   capture eng_s_out/eng_pos_out into resp_* and go RESP. Counter +1 per cycle; if TIMEOUT!=0
//   and counter reaches TIMEOUT-1 without done -> ABORT.
//  RESP: ack[grant_idx]=1 for one cycle, resp_* held; rr_ptr <= grant_idx+1 mod NUM_REQ; go IDLE.
//  ABORT: err[grant_idx]=1 for one cycle, resp_* unchanged; rr_ptr advanced as in RESP; go IDLE.
//  Latency: req seen in IDLE at cycle T -> eng_start at T+2; eng_done at cycle D -> ack at D+1.
//   Back-to-back jobs: next grant decision in the IDLE cycle after RESP (one IDLE cycle minimum).
//  Inputs latched at grant; changing req_* after grant does not affect the job. A req bit dropped
//   after grant still receives its ack. Requester must drop req in cycle after ack or it is re-queued
//   (served again only after others per round-robin).
//  resp_* retain last value outside RESP; ack and err never high together; at most one bit each.
//  grant_idx holds last granted index in IDLE; busy=0 only in IDLE.
//  Unused grant_idx high bits 0. NUM_REQ outside 2..8 is a elaboration error.
// TESTING
//  1 single req[2], engine done 10 cycles after start -> eng_start at T+2, eng_* = slot 2 data,
//    ack=4'b0100 exactly at done+1, resp_pos_out = eng_pos_out, busy low next cycle.
//  2 req=4'b1111 held, rr_ptr=0 -> grant order 0,1,2,3,0 with one IDLE cycle between jobs; ack
//    bits follow same order.
//  3 req[1] job running, req[0] and req[3] assert -> after ack[1], grant 3 then 0 (rr_ptr=2).
//  4 TIMEOUT=16, engine never asserts done -> err[grant_idx] pulse 16 cycles after START, no ack,
//    resp_* unchanged, next request served normally.
//  5 reset low during WAIT -> all outputs 0 immediately (async), after release IDLE, rr_ptr=0,
//    no ack/err for abandoned job.
//  6 req_s_in of granted slot changed during WAIT, eng_done level-held 3 cycles -> eng_s_in
//    unchanged, exactly one ack pulse.

Source files
------------

// File: rtl/shake128_absorb_arbiter.sv
// Round-robin front end that time-shares a single shake128_absorb engine among NUM_REQ requesters.
// Latches the winner's state/message, pulses the engine start, and returns the result with a one-cycle ack.
module shake128_absorb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IN_LEN  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*1600-1:0]       req_s_in,
  input  logic [NUM_REQ*32-1:0]         req_pos_in,
  input  logic [NUM_REQ*IN_LEN*8-1:0]   req_in,
  input  logic [NUM_REQ*64-1:0]         req_inlen,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            err,
  output logic [1599:0]                 resp_s_out,
  output logic [31:0]                   resp_pos_out,
  output logic                          busy,
  output logic [2:0]                    grant_idx,
  output logic                          eng_start,
  output logic [1599:0]                 eng_s_in,
  output logic [31:0]                   eng_pos_in,
  output logic [IN_LEN*8-1:0]           eng_in,
  output logic [63:0]                   eng_inlen,
  input  logic [1599:0]                 eng_s_out,
  input  logic [31:0]                   eng_pos_out,
  input  logic                          eng_done
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("shake128_absorb_arbiter: NUM_REQ must be in 2..8");
  end

  localparam logic [31:0] TMO_LAST = 32'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RESP, ABORT} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [2:0]           rr_ptr;
  logic [31:0]          wd_cnt;
  logic                 pick_vld;
  logic [2:0]           pick_idx;
  logic [7:0]           req_pad;
  logic [7:0]           grant_oh;

  // Per-slot views padded to 8 entries so a 3-bit index always addresses them exactly
  logic [1599:0]        slot_s     [8];
  logic [31:0]          slot_pos   [8];
  logic [IN_LEN*8-1:0]  slot_in    [8];
  logic [63:0]          slot_inlen [8];

  for (genvar k = 0; k < 8; k++) begin : g_slot
    if (k < NUM_REQ) begin : g_used
      assign slot_s[k]     = req_s_in[k*1600 +: 1600];
      assign slot_pos[k]   = req_pos_in[k*32 +: 32];
      assign slot_in[k]    = req_in[k*IN_LEN*8 +: IN_LEN*8];
      assign slot_inlen[k] = req_inlen[k*64 +: 64];
    end else begin : g_unused
      assign slot_s[k]     = '0;
      assign slot_pos[k]   = '0;
      assign slot_in[k]    = '0;
      assign slot_inlen[k] = '0;
    end
  end

  function automatic logic [2:0] next_idx(input logic [2:0] g);
    return (g == 3'(NUM_REQ - 1)) ? 3'd0 : g + 3'd1;
  endfunction

  assign req_pad  = 8'(req);
  assign grant_oh = 8'd1 << grant_idx;

  // Round-robin scan starting at rr_ptr
  always_comb begin
    logic [3:0] j;
    pick_vld = 1'b0;
    pick_idx = 3'd0;
    j        = 4'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = {1'b0, rr_ptr} + 4'(i);
      if (j >= 4'(NUM_REQ)) j = j - 4'(NUM_REQ);
      if (!pick_vld && req_pad[j[2:0]]) begin
        pick_vld = 1'b1;
        pick_idx = j[2:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (pick_vld) state_nxt = LOAD;
      LOAD:  state_nxt = START;
      START: state_nxt = WAIT;
      WAIT: begin
        if (eng_done)                                              state_nxt = RESP;
        else if (TIMEOUT != 0 && (wd_cnt + 32'd1) >= TMO_LAST)     state_nxt = ABORT;
      end
      RESP:    state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    eng_start = (state == START);
    ack       = (state == RESP)  ? grant_oh[NUM_REQ-1:0] : '0;
    err       = (state == ABORT) ? grant_oh[NUM_REQ-1:0] : '0;
  end

  // Grant latch, engine operand registers, watchdog and response capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr       <= 3'd0;
      grant_idx    <= 3'd0;
      wd_cnt       <= 32'd0;
      eng_s_in     <= '0;
      eng_pos_in   <= '0;
      eng_in       <= '0;
      eng_inlen    <= '0;
      resp_s_out   <= '0;
      resp_pos_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_idx  <= pick_idx;
            eng_s_in   <= slot_s[pick_idx];
            eng_pos_in <= slot_pos[pick_idx];
            eng_in     <= slot_in[pick_idx];
            eng_inlen  <= slot_inlen[pick_idx];
          end
        end
        START: wd_cnt <= 32'd0;
        WAIT: begin
          if (eng_done) begin
            resp_s_out   <= eng_s_out;
            resp_pos_out <= eng_pos_out;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
        end
        RESP, ABORT: rr_ptr <= next_idx(grant_idx);
        default: ;
      endcase
    end
  end

endmodule
